// File: rtl/spec_carry_pkg.sv
// Shared definitions for the speculative carry corrector: state encoding,
// default geometry and the segment-count derivation.
package spec_carry_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EVAL = 2'd1,
    S_FIX  = 2'd2,
    S_HOLD = 2'd3
  } state_t;

  localparam int WIDTH_DEF = 16;
  localparam int SEG_DEF   = 4;
  localparam int CNT_W_DEF = 16;

  function automatic int nseg_f(input int width, input int seg);
    return width / seg;
  endfunction

endpackage

// File: rtl/spec_carry_corrector_seg_add.sv
// SEG-bit ripple adder used both for the parallel speculative row and for
// the shared segment-serial repair path.
module seg_add
  import spec_carry_pkg::*;
#(
  parameter int SEG = SEG_DEF
) (
  input  logic [SEG-1:0] x,
  input  logic [SEG-1:0] y,
  input  logic           ci,
  output logic [SEG-1:0] s,
  output logic           co
);

  assign {co, s} = {1'b0, x} + {1'b0, y} + {{SEG{1'b0}}, ci};

endmodule

// File: rtl/spec_carry_corrector.sv
// Speculative segmented adder back end: forms the sum from the sel_unit carry
// guesses, flags mis-speculation and optionally repairs it one segment per cycle.
module spec_carry_corrector
  import spec_carry_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int SEG   = SEG_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [WIDTH-1:0]              a,
  input  logic [WIDTH-1:0]              b,
  input  logic                          cin,
  input  logic [nseg_f(WIDTH, SEG)-2:0] sel,
  input  logic                          exact_en,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [WIDTH-1:0]              sum,
  output logic                          cout,
  output logic                          err,
  input  logic                          cnt_clr,
  output logic [CNT_W-1:0]              err_cnt
);

  localparam int NSEG = nseg_f(WIDTH, SEG);
  localparam int KW   = (NSEG > 2) ? $clog2(NSEG) : 1;
  localparam logic [KW-1:0]    K_LAST  = KW'(NSEG - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic              cin_q, cin_d;
  logic [NSEG-2:0]   sel_q, sel_d;
  logic              exact_q, exact_d;
  logic [WIDTH-1:0]  sum_q, sum_d;
  logic              cout_q, cout_d;
  logic              err_q, err_d;
  logic [KW-1:0]     k_q, k_d;
  logic              cr_q, cr_d;
  logic [CNT_W-1:0]  err_cnt_q, err_cnt_d;
  logic              in_ready_q, in_ready_d;
  logic              out_valid_q, out_valid_d;

  logic [WIDTH-1:0]  spec_sum_s;
  logic [NSEG-1:0]   co_s;
  logic [NSEG-1:0]   mis_s;
  logic              mis_any_s;
  logic [KW-1:0]     k_first_s;
  logic              cr_first_s;
  logic [SEG-1:0]    fix_x_s;
  logic [SEG-1:0]    fix_y_s;
  logic [SEG-1:0]    fix_s_s;
  logic              fix_co_s;

  // Speculative row: segment 0 takes the true cin, the rest take their sel guess.
  for (genvar g = 0; g < NSEG; g++) begin : g_seg
    logic ci_s;
    if (g == 0) begin : g_lo
      assign ci_s = cin_q;
    end else begin : g_hi
      assign ci_s = sel_q[g-1];
    end
    seg_add #(.SEG(SEG)) u_seg (
      .x  (a_q[g*SEG +: SEG]),
      .y  (b_q[g*SEG +: SEG]),
      .ci (ci_s),
      .s  (spec_sum_s[g*SEG +: SEG]),
      .co (co_s[g])
    );
  end

  // Mis-speculation vector and the lowest wrong segment with its true carry-in.
  always_comb begin
    mis_s      = '0;
    k_first_s  = '0;
    cr_first_s = 1'b0;
    for (int j = NSEG - 1; j >= 1; j--) begin
      mis_s[j] = (co_s[j-1] != sel_q[j-1]);
      if (mis_s[j]) begin
        k_first_s  = KW'(j);
        cr_first_s = co_s[j-1];
      end else begin
        k_first_s  = k_first_s;
        cr_first_s = cr_first_s;
      end
    end
    mis_any_s = |mis_s;
  end

  // Operand slice for the single shared repair adder.
  always_comb begin
    fix_x_s = a_q[SEG*int'(k_q) +: SEG];
    fix_y_s = b_q[SEG*int'(k_q) +: SEG];
  end

  seg_add #(.SEG(SEG)) u_fix (
    .x  (fix_x_s),
    .y  (fix_y_s),
    .ci (cr_q),
    .s  (fix_s_s),
    .co (fix_co_s)
  );

  // Next-state, datapath and counter update.
  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    cin_d     = cin_q;
    sel_d     = sel_q;
    exact_d   = exact_q;
    sum_d     = sum_q;
    cout_d    = cout_q;
    err_d     = err_q;
    k_d       = k_q;
    cr_d      = cr_q;
    err_cnt_d = err_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          cin_d   = cin;
          sel_d   = sel;
          exact_d = exact_en;
          state_d = S_EVAL;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_EVAL: begin
        sum_d = spec_sum_s;
        if (!mis_any_s || !exact_q) begin
          cout_d  = co_s[NSEG-1];
          err_d   = mis_any_s;
          state_d = S_HOLD;
        end else begin
          err_d   = 1'b1;
          k_d     = k_first_s;
          cr_d    = cr_first_s;
          state_d = S_FIX;
        end
      end
      S_FIX: begin
        sum_d[SEG*int'(k_q) +: SEG] = fix_s_s;
        cr_d = fix_co_s;
        if (k_q == K_LAST) begin
          cout_d  = fix_co_s;
          state_d = S_HOLD;
        end else begin
          k_d = k_q + KW'(1);
        end
      end
      S_HOLD: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_HOLD;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A clear issued on an increment edge takes priority.
    if (cnt_clr) begin
      err_cnt_d = '0;
    end else if (state_q == S_EVAL && mis_any_s && err_cnt_q != CNT_MAX) begin
      err_cnt_d = err_cnt_q + CNT_W'(1);
    end else begin
      err_cnt_d = err_cnt_q;
    end

    in_ready_d  = (state_d == S_IDLE);
    out_valid_d = (state_d == S_HOLD);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      cin_q       <= 1'b0;
      sel_q       <= '0;
      exact_q     <= 1'b0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      err_q       <= 1'b0;
      k_q         <= '0;
      cr_q        <= 1'b0;
      err_cnt_q   <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      cin_q       <= cin_d;
      sel_q       <= sel_d;
      exact_q     <= exact_d;
      sum_q       <= sum_d;
      cout_q      <= cout_d;
      err_q       <= err_d;
      k_q         <= k_d;
      cr_q        <= cr_d;
      err_cnt_q   <= err_cnt_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign err       = err_q;
  assign err_cnt   = err_cnt_q;

endmodule

// File: doc/spec_carry_corrector.md
Name: spec_carry_corrector

Overview:
- Downstream consumer of the per-segment carry-select signals (sel_i) produced by the selection-unit row of the segmented approximate adder.
- Uses each sel bit as the speculated carry-in of its segment and forms the speculative sum in one evaluation cycle.
- Detects mis-speculated segments. In exact mode it repairs them by iterative segment-serial recompute; in approximate mode it returns the speculative result with an error flag.
- Counts mis-speculated transactions for error-rate statistics.

Parameters:
- WIDTH, 16, operand/sum width; must be a multiple of SEG.
- SEG, 4, segment width in bits; NSEG = WIDTH/SEG (localparam, at least 2).
- CNT_W, 16, width of the saturating error counter.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand transaction valid.
- in_ready  output  1  block can accept operands.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry into segment 0 (exact, never speculated).
- sel  input  NSEG-1  speculated carry-in from the sel_unit row; sel[j-1] feeds segment j.
- exact_en  input  1  1 = correct mis-speculation, 0 = approximate result.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- sum  output  WIDTH  result sum.
- cout  output  1  carry out of the top segment.
- err  output  1  at least one segment was mis-speculated in this transaction.
- cnt_clr  input  1  synchronous clear of err_cnt.
- err_cnt  output  CNT_W  saturating count of transactions with err=1.

Behaviour:
- Reset (async, rst_n=0): state IDLE; in_ready=1 after release; out_valid=0, sum=0, cout=0, err=0, err_cnt=0. All captured operands are cleared. Reset at any state, including mid-FIX, aborts the transaction with no output.
- States: IDLE, EVAL, FIX, HOLD. Encoding is binary, defined in the package.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid=1, capture a, b, cin, sel and exact_en, then go to EVAL.
  - In all other states in_ready=0 and in_valid is ignored.
- EVAL, one cycle:
  - Segment 0 adds with cin.
  - Segment j≥1 adds with sel[j-1], giving spec_sum and co[j].
  - mis[j] = (co[j-1] != sel[j-1]) for j=1..NSEG-1.
  - If mis==0 or exact_en=0: register sum=spec_sum, cout=co[NSEG-1], err=|mis, then go to HOLD.
  - Otherwise: err=1; k = index of the lowest set mis bit; carry register cr = co[k-1]; segments below k keep their spec_sum values; go to FIX.
- FIX, one segment per cycle:
  - Recompute segment k with carry-in cr and write its sum slice.
  - cr <= carry out of segment k.
  - If k == NSEG-1: cout <= that carry and go to HOLD; else k <= k+1.
  - All segments from k upward are recomputed even if their own sel was correct.
- Latency, counted from the accepting edge to the first cycle with out_valid=1:
  - 2 edges with no correction.
  - 2 + (NSEG - k) edges with correction.
  - Worst case with the default parameters (k=1) is 5 edges.
- HOLD: out_valid=1; sum, cout and err are stable. On an edge with out_ready=1, go to IDLE and drop out_valid. No bypass: a new operand can be accepted at the earliest one cycle after the output handshake.
- err_cnt:
  - Increments on the EVAL edge when |mis=1, in both modes.
  - Saturates at all-ones.
  - cnt_clr=1 clears it on the next edge; a clear in the same cycle as an increment wins, giving 0.
- Arithmetic: modulo 2^WIDTH. In exact mode the result equals a+b+cin exactly. In approximate mode the sum differs only in segments with a wrong carry-in.

Decomposition:
- Package spec_carry_pkg holds:
  - the state encoding constants (IDLE=0, EVAL=1, FIX=2, HOLD=3);
  - the default WIDTH, SEG and CNT_W;
  - the NSEG derivation.
- Sub-module seg_add: SEG-bit ripple adder with inputs x, y, ci and outputs s, co.
  - NSEG instances form the EVAL datapath.
  - One shared instance, with mux-selected operand slices, forms the FIX datapath.

Test Plan:
- Correct speculation: a=0x1234, b=0x1111, cin=0, sel=3'b000, exact_en=1 -> sum=0x2345, cout=0, err=0, out_valid 2 edges after accept, err_cnt unchanged.
- Under-speculation, approximate: a=0x000F, b=0x0001, sel=3'b000, exact_en=0 -> sum=0x0000, cout=0, err=1, latency 2, err_cnt=1.
- Under-speculation, exact: same operands with exact_en=1 -> sum=0x0010, err=1, k=1, out_valid 5 edges after accept. Also a=0xFFFF, b=0x0001, sel=0 -> sum=0x0000, cout=1.
- Over-speculation: a=0x0000, b=0x0000, sel=3'b111:
  - exact_en=0 -> sum=0x1110, err=1;
  - exact_en=1 -> sum=0x0000, cout=0.
- Backpressure and handshake: hold out_ready=0 for 3 cycles in HOLD -> sum/err stable, in_ready=0, a concurrent in_valid is not captured; out_ready=1 -> IDLE next edge.
- Reset and counter:
  - rst_n pulsed low during FIX -> out_valid=0 immediately, err_cnt=0, in_ready=1 after release.
  - CNT_W=2 with 4 error transactions -> err_cnt=3 (saturated).
  - cnt_clr asserted on an increment edge -> err_cnt=0.
